// File: rtl/pool2_maxpool_reader.sv
// 2x2 / stride-2 max-pool over the conv2 result buffer (CH maps of IN_DIM x IN_DIM).
// One read per cycle through a 1-cycle-latency port; one write per pooled window.
module pool2_maxpool_reader #(
  parameter int CH      = 32,
  parameter int IN_DIM  = 14,
  parameter int OUT_DIM = 7,
  parameter int DW      = 32,
  parameter int RA_W    = 13,
  parameter int WA_W    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [RA_W-1:0]      rd_addr,
  input  logic signed [DW-1:0] rd_data,
  output logic                 wr_en,
  output logic [WA_W-1:0]      wr_addr,
  output logic signed [DW-1:0] wr_data
);

  localparam int C_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int O_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [C_W-1:0]  C_LAST   = C_W'(CH - 1);
  localparam logic [O_W-1:0]  O_LAST   = O_W'(OUT_DIM - 1);
  localparam logic [WA_W-1:0] WIN_LAST = WA_W'(CH * OUT_DIM * OUT_DIM - 1);

  // Offsets of the four window taps from the window's top-left address, and the
  // step from one window's top-left to the next (wrapping to the next row pair
  // or next map both advance by IN_DIM+2).
  localparam logic [RA_W-1:0] OFF_R     = RA_W'(1);
  localparam logic [RA_W-1:0] OFF_D     = RA_W'(IN_DIM);
  localparam logic [RA_W-1:0] OFF_DR    = RA_W'(IN_DIM + 1);
  localparam logic [RA_W-1:0] STEP_COL  = RA_W'(2);
  localparam logic [RA_W-1:0] STEP_WRAP = RA_W'(IN_DIM + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [C_W-1:0]  c_p0;
  logic [O_W-1:0]  oi_p0;
  logic [O_W-1:0]  oj_p0;
  logic [1:0]      sub_p0;
  logic [RA_W-1:0] win_base_p0;

  logic            vld_p1;
  logic [1:0]      sub_p1;

  logic signed [DW-1:0] max_p2;
  logic signed [DW-1:0] max_nxt;
  logic [WA_W-1:0]      win_p2;

  logic start_acc;
  logic last_rd;
  logic last_wr;

  function automatic logic signed [DW-1:0] pick_max(input logic signed [DW-1:0] cur,
                                                    input logic signed [DW-1:0] cand);
    // Strictly greater replaces; ties keep the held value.
    return (cand > cur) ? cand : cur;
  endfunction

  assign start_acc = (state == S_IDLE) && start;
  assign last_rd   = rd_en && (sub_p0 == 2'd3) && (c_p0 == C_LAST) &&
                     (oi_p0 == O_LAST) && (oj_p0 == O_LAST);
  assign last_wr   = wr_en && (wr_addr == WIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)   state_nxt = S_READ;
      S_READ:  if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: if (last_wr) state_nxt = S_DONE;
      S_DONE:               state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start_acc) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if ((state == S_DRAIN) && last_wr) begin
      busy <= 1'b0;
      done <= 1'b1;
    end
  end

  // ---- stage p0: read address generation ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      sub_p0      <= '0;
      c_p0        <= '0;
      oi_p0       <= '0;
      oj_p0       <= '0;
      win_base_p0 <= '0;
    end else if (start_acc) begin
      rd_en       <= 1'b1;
      rd_addr     <= '0;
      sub_p0      <= '0;
      c_p0        <= '0;
      oi_p0       <= '0;
      oj_p0       <= '0;
      win_base_p0 <= '0;
    end else if (rd_en) begin
      if (last_rd) begin
        rd_en <= 1'b0;
      end else begin
        sub_p0 <= sub_p0 + 2'd1;
        unique case (sub_p0)
          2'd0: rd_addr <= win_base_p0 + OFF_R;
          2'd1: rd_addr <= win_base_p0 + OFF_D;
          2'd2: rd_addr <= win_base_p0 + OFF_DR;
          default: begin
            if (oj_p0 == O_LAST) begin
              rd_addr     <= win_base_p0 + STEP_WRAP;
              win_base_p0 <= win_base_p0 + STEP_WRAP;
              oj_p0       <= '0;
              if (oi_p0 == O_LAST) begin
                oi_p0 <= '0;
                c_p0  <= c_p0 + C_W'(1);
              end else begin
                oi_p0 <= oi_p0 + O_W'(1);
              end
            end else begin
              rd_addr     <= win_base_p0 + STEP_COL;
              win_base_p0 <= win_base_p0 + STEP_COL;
              oj_p0       <= oj_p0 + O_W'(1);
            end
          end
        endcase
      end
    end
  end

  // ---- stage p1: tag aligned with returning rd_data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sub_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      sub_p1 <= sub_p0;
    end
  end

  // First tap loads directly so all-negative windows pool correctly.
  assign max_nxt = (sub_p1 == 2'd0) ? rd_data : pick_max(max_p2, rd_data);

  // ---- stage p2: running max and pooled write ----
  always_ff @(posedge clk) begin
    if (vld_p1) max_p2 <= max_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      win_p2  <= '0;
    end else begin
      wr_en <= vld_p1 && (sub_p1 == 2'd3);
      if (start_acc) win_p2 <= '0;
      if (vld_p1 && (sub_p1 == 2'd3)) begin
        wr_addr <= win_p2;
        wr_data <= max_nxt;
        win_p2  <= win_p2 + WA_W'(1);
      end
    end
  end

endmodule

// File: doc/pool2_maxpool_reader.md
# pool2_maxpool_reader

Second-stage 2x2/stride-2 max-pool block that consumes the conv2 output feature memory (32 maps of 14x14, signed 32-bit, post-ReLU) through a synchronous read port. It writes the 32 pooled 7x7 maps to a pooled-feature memory through a write port. It is the reading end of the conv2 result buffer: conv2 writes the buffer, and this block drains it after conv2 `done`. It issues one read per cycle, fully pipelined, and uses a start/done handshake to the layer sequencer.

## Interface
Parameters:
- CH, 32: number of feature maps.
- IN_DIM, 14: input map height/width; must be even.
- OUT_DIM, 7: output map height/width; equals IN_DIM/2.
- DW, 32: data width, signed.
- RA_W, 13: read address width; holds CH*IN_DIM*IN_DIM-1 (6271).
- WA_W, 11: write address width; holds CH*OUT_DIM*OUT_DIM-1 (1567).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a pooling pass; sampled only when not busy.
- busy  out  1  pass in progress.
- done  out  1  pass complete; held high until the next accepted start.
- rd_en  out  1  read strobe to the conv2 result memory.
- rd_addr  out  RA_W  read address = c*196 + row*14 + col.
- rd_data  in  DW  signed read data; valid in the cycle after rd_en (1-cycle latency).
- wr_en  out  1  write strobe to the pooled memory.
- wr_addr  out  WA_W  write address = c*49 + oi*7 + oj.
- wr_data  out  DW  signed pooled maximum.

## Operation
- States:
  - IDLE: start goes to READ and clears done.
  - READ: issues CH*OUT_DIM*OUT_DIM*4 reads back to back, then goes to DRAIN.
  - DRAIN: waits for the last data and write, then goes to DONE.
  - DONE: sets done and goes to IDLE.
- Read order uses nested counters c (outer), then oi, then oj, then sub (inner, 0..3). sub order is (2oi,2oj), (2oi,2oj+1), (2oi+1,2oj), (2oi+1,2oj+1).
- Addresses are generated by incremental base registers; no runtime multiplier is required.
- Data path pipeline:
  - rd_en/sub tag delayed 1 cycle to align with rd_data.
  - sub==0 data loads the running max directly; there is no compare against 0, so negative inputs pool correctly.
  - sub 1..3 replace the running max if rd_data > max (signed compare); ties keep the current value.
- After the sub==3 data, the block registers wr_en=1 for one cycle with wr_addr of that window and wr_data equal to the final max.
- Write order is strictly ascending wr_addr 0..1567, one write per window, with no gaps in the count.
- start while busy is ignored. start while done=1 and IDLE is accepted; done drops the next cycle.
- Asynchronous reset mid-pass:
  - All outputs go to 0 immediately and the state goes to IDLE.
  - No further rd_en or wr_en; pipeline tags are cleared.
  - The next start restarts from address 0.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0.

## Timing
- Cycle 0: start sampled high at the closing edge in IDLE.
- Cycle 1+q: rd_en=1 with read q (q=0..6271). rd_en is continuous for 6272 cycles.
- Cycle 2+q: rd_data for read q is valid; it is captured at the closing edge.
- Window k (reads 4k..4k+3): wr_en=1 in cycle 4k+6. First write is in cycle 6; last write (k=1567) is in cycle 6274.
- busy is high in cycles 1..6274. done rises in cycle 6275. Total pass is 6275 cycles from start.
- rd_en and wr_en overlap; the read and write memories are independent.

## Test plan
- Ramp memory mem[a]=a, start at cycle 0:
  - wr_data for k=0 is 15, for k=48 is 195, for k=49 is 211, and for k=1567 is 6271.
  - 1568 writes in total, wr_addr ascending.
- Window-position check: all inputs -5 except one -3 at each of the 4 sub positions of window 0 in turn. wr_data[0]=-3 in every case; all other windows write -5.
- Cycle check:
  - First rd_en in cycle 1 with addr 0.
  - First wr_en in cycle 6 with addr 0.
  - Last wr_en in cycle 6274 with addr 1567.
  - done=1 from cycle 6275 and held.
  - busy drops in cycle 6275.
- start pulsed at cycles 100 and 3000 during a pass: ignored, and the write count stays at 1568. A start after done clears done one cycle later and repeats the identical write stream.
- Reset asserted at cycle 3000:
  - All outputs are 0 in the same cycle, and no rd_en or wr_en appears afterward.
  - A new start yields rd_addr 0 in cycle 1 and a full correct pass.
- Tie handling: all four window inputs equal to 7 give wr_data=7. All zeros give 0, matching post-ReLU conv2 output.
